// File: rtl/fpu_pkg.sv
// Shared FPU constants: rounding-mode encodings and requester ids.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fpu_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;  // round to nearest, ties to even
    localparam logic [1:0] RM_RDN = 2'b01;  // round toward -inf
    localparam logic [1:0] RM_RUP = 2'b10;  // round toward +inf
    localparam logic [1:0] RM_RTZ = 2'b11;  // round toward zero

    localparam logic REQ_FPU = 1'b0;        // FP issue stage
    localparam logic REQ_DIV = 1'b1;        // divide/sqrt sequencer

endpackage

// File: rtl/fmul_arb2.sv
// Two-way arbiter for the shared multiplier: round-robin or fixed priority.
// Latency: grants are combinational; the rr pointer updates on the clock.
// Backpressure: no grant at all while en is low (stall, flush or reset).
//
// Ports: clk/rst, en (grant permitted this cycle), req0/req1 (requests),
//        gnt0/gnt1 (one-hot-or-zero grants).
module fmul_arb2
    import fpu_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // Favoured requester when both contend (round-robin mode only).
    logic rr;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                if (FIXED_PRIO != 0 || rr == REQ_FPU) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // The pointer only moves on real contention, so a lone requester
    // does not steal the other's next turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= REQ_FPU;
        end else if (FIXED_PRIO == 0 && en && req0 && req1) begin
            rr <= ~rr;
        end
    end

endmodule

// File: rtl/fmul_ctrl.sv
// Shares one pipelined FP multiplier between the issue stage and the div/sqrt sequencer.
// Latency: op accepted in cycle t returns res_valid in cycle t+STAGES; 1 op/cycle.
// Backpressure: res_ready low with a result waiting stalls the whole pipe and drops both readies.
//
// Ports: req0_*/req1_* requester inputs with *_ready accepts; flush cancels in-flight ops;
//        mul_a/mul_b/stage_en/norm_rm drive the datapath, fmul_s is its result;
//        res_* is the valid/ready result port; busy = any stage occupied.
module fmul_ctrl
    import fpu_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int TAG_W      = 5,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [31:0]       req0_a,
    input  logic [31:0]       req0_b,
    input  logic [1:0]        req0_rm,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [31:0]       req1_a,
    input  logic [31:0]       req1_b,
    input  logic [1:0]        req1_rm,
    input  logic [TAG_W-1:0]  req1_tag,
    input  logic              flush,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    output logic [STAGES-1:0] stage_en,
    output logic [1:0]        norm_rm,
    input  logic [31:0]       fmul_s,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic [TAG_W-1:0]  res_tag,
    output logic [31:0]       res_s,
    output logic              busy
);

    typedef struct packed {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [1:0]       rm;
    } meta_t;

    logic [STAGES-1:0] v;
    meta_t             meta [STAGES];
    meta_t             meta_in;
    logic              adv;
    logic              gnt0;
    logic              gnt1;
    logic              grant_any;

    // Global stall: everything moves unless a finished result is blocked.
    // Reset is folded in so readies and stage enables are low while it is held.
    assign adv = (~v[STAGES-1] | res_ready) & ~rst;

    fmul_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (adv & ~flush),
        .req0 (req0_valid),
        .req1 (req1_valid),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign grant_any  = gnt0 | gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Default to requester 0 when idle; v[0] loads 0 so the operands are ignored.
    assign mul_a = gnt1 ? req1_a : req0_a;
    assign mul_b = gnt1 ? req1_b : req0_b;

    always_comb begin
        meta_in.id  = gnt1 ? REQ_DIV : REQ_FPU;
        meta_in.tag = gnt1 ? req1_tag : req0_tag;
        meta_in.rm  = gnt1 ? req1_rm  : req0_rm;
    end

    // Metadata is not cleared by flush; only the valid bits matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) begin
                meta[i] <= '0;
            end
        end else begin
            if (flush) begin
                v <= '0;
            end else if (adv) begin
                v <= {v[STAGES-2:0], grant_any};
            end
            if (adv) begin
                meta[0] <= meta_in;
                for (int i = 1; i < STAGES; i++) begin
                    meta[i] <= meta[i-1];
                end
            end
        end
    end

    assign stage_en  = {STAGES{adv}};
    assign res_valid = v[STAGES-1];
    assign res_id    = meta[STAGES-1].id;
    assign res_tag   = meta[STAGES-1].tag;
    assign norm_rm   = meta[STAGES-1].rm;
    assign res_s     = fmul_s;
    assign busy      = |v;

endmodule
